sigdel_cic_decim: RTL and testbench



---
 rtl/sigdel_cic_decim.sv | 96 +++++++++
 tb/tb_sigdel_cic_decim.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sigdel_cic_decim.sv
// Decimating CIC filter for a 1-bit sigma-delta bitstream.
// Integrators run at the bit rate, the combs at 1/R, and a one-entry valid/ready holding register feeds the reader.
module sigdel_cic_decim #(
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 5,
  parameter int ACC_W      = ORDER * DECIM_LOG2 + 1,
  parameter int OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  logic [DECIM_LOG2-1:0] cnt;
  logic [ACC_W-1:0]      integ_q [ORDER];
  logic [ACC_W-1:0]      integ_d [ORDER];
  logic [ACC_W-1:0]      dly_q   [ORDER];
  logic [ACC_W-1:0]      comb_in [ORDER];
  logic [ACC_W-1:0]      comb_out;

  logic accept;
  logic decim_pt;
  logic ovr_set;

  assign accept   = en & bit_valid;
  assign decim_pt = accept && (cnt == {DECIM_LOG2{1'b1}});
  assign ovr_set  = decim_pt & out_valid & ~out_ready;

  // Ripple-through integrators. A single running sum keeps each stage a
  // plain function of the previous one, with no feedback through the array.
  always_comb begin
    logic [ACC_W-1:0] run;
    // NOTE: every combinational output gets a default before any conditional
    // logic; this is what keeps always_comb from inferring latches.
    run = ACC_W'(bit_in);
    for (int k = 0; k < ORDER; k++) begin
      run        = integ_q[k] + run;
      integ_d[k] = run;
    end
  end

  // Comb chain, differential delay 1 at the decimated rate.
  // comb_in[k] is the value latched into dly_q[k] at the decimation point.
  always_comb begin
    logic [ACC_W-1:0] c;
    c = integ_d[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = c;
      c          = c - dly_q[k];
    end
    comb_out = c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      // NOTE: the filter state is a handful of registers rather than a RAM,
      // so it is cleared outright; a stale integrator would corrupt every
      // sample after reset.
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // NOTE: all state updates use non-blocking assignments, so every
      // register samples pre-edge values regardless of statement order.
      if (accept) begin
        cnt <= cnt + DECIM_LOG2'(1);
        for (int k = 0; k < ORDER; k++) integ_q[k] <= integ_d[k];
      end

      if (decim_pt) begin
        for (int k = 0; k < ORDER; k++) dly_q[k] <= comb_in[k];
        out_data  <= comb_out[ACC_W-1 -: OUT_W];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A new overrun in the same cycle as clr_ovr takes priority.
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sigdel_cic_decim.sv
// Directed bench for sigdel_cic_decim with default parameters (R=32, N=3, 16-bit output).
module tb_sigdel_cic_decim;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overrun;
  logic        clr_ovr = 1'b0;

  int total = 0;
  int bad   = 0;

  sigdel_cic_decim dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus; outputs are stable 1 time unit after the edge.
  task automatic cyc(input logic b, input logic v, input logic e);
    bit_in = b; bit_valid = v; en = e;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr_ovr = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", out_data); end
  endtask

  task automatic test_zeros();
    int pulses = 0;
    do_reset();
    out_ready = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (out_valid === 1'b1) begin
        pulses++;
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL zeros_data n=%0d got=%h exp=0000", n, out_data); end
      end
    end
    total++; if (pulses != 6) begin bad++; $display("FAIL zeros_pulses got=%0d exp=6", pulses); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL zeros_ovr got=%b exp=0", overrun); end
  endtask

  task automatic test_ones();
    logic [15:0] exp_v [4] = '{16'd5984, 16'd27808, 16'd32768, 16'd32768};
    int idx = 0;
    do_reset();
    out_ready = 1'b1;
    for (int n = 1; n <= 128; n++) begin
      cyc(1'b1, 1'b1, 1'b1);
      total++;
      if (out_valid !== (n % 32 == 0)) begin bad++; $display("FAIL ones_valid n=%0d got=%b exp=%b", n, out_valid, (n % 32 == 0)); end
      if (n % 32 == 0) begin
        total++; if (out_data !== exp_v[idx]) begin bad++; $display("FAIL ones_data k=%0d got=%0d exp=%0d", idx + 1, out_data, exp_v[idx]); end
        idx++;
      end
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ones_ovr got=%b exp=0", overrun); end
  endtask

  task automatic test_alternating();
    int idx = 0;
    do_reset();
    out_ready = 1'b1;
    for (int n = 1; n <= 160; n++) begin
      cyc(logic'(n % 2), 1'b1, 1'b1);
      if (n % 32 == 0) begin
        idx++;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL alt_valid k=%0d got=%b exp=1", idx, out_valid); end
        if (idx >= 3) begin
          total++; if (out_data !== 16'd16384) begin bad++; $display("FAIL alt_data k=%0d got=%0d exp=16384", idx, out_data); end
        end
      end
    end
  endtask

  // Sparse bit_valid plus an en=0 window; only accepted bits advance the frame.
  task automatic test_gaps();
    logic [15:0] exp_v [2] = '{16'd5984, 16'd27808};
    int acc = 0;
    int idx = 0;
    int c = 0;
    logic v, e, took;
    do_reset();
    out_ready = 1'b1;
    while (acc < 64 && c < 1000) begin
      v = (c % 3 == 0);
      e = !(c >= 40 && c < 50);
      took = v & e;
      cyc(1'b1, (c >= 40 && c < 50) ? 1'b1 : v, e);
      if (took) acc++;
      total++;
      if (out_valid !== (took && acc % 32 == 0)) begin
        bad++; $display("FAIL gaps_valid cyc=%0d acc=%0d got=%b exp=%b", c, acc, out_valid, (took && acc % 32 == 0));
      end
      if (took && acc % 32 == 0) begin
        total++; if (out_data !== exp_v[idx]) begin bad++; $display("FAIL gaps_data k=%0d got=%0d exp=%0d", idx + 1, out_data, exp_v[idx]); end
        idx++;
      end
      c++;
    end
    total++; if (idx != 2) begin bad++; $display("FAIL gaps_count got=%0d exp=2", idx); end
  endtask

  task automatic test_overrun();
    do_reset();
    out_ready = 1'b0;
    for (int n = 1; n <= 32; n++) cyc(1'b1, 1'b1, 1'b1);
    total++; if (out_valid !== 1'b1 || out_data !== 16'd5984) begin bad++; $display("FAIL ovr_first got=%b/%0d exp=1/5984", out_valid, out_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_first_flag got=%b exp=0", overrun); end
    for (int n = 1; n <= 32; n++) cyc(1'b1, 1'b1, 1'b1);
    total++; if (out_valid !== 1'b1 || out_data !== 16'd27808) begin bad++; $display("FAIL ovr_second got=%b/%0d exp=1/27808", out_valid, out_data); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    // Idle cycle: flag is sticky.
    cyc(1'b1, 1'b0, 1'b1);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    clr_ovr = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    clr_ovr = 1'b0;
    total++; if (overrun !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL ovr_clear got=%b/%b exp=0/1", overrun, out_valid); end
    for (int n = 1; n <= 31; n++) cyc(1'b1, 1'b1, 1'b1);
    out_ready = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    total++; if (out_valid !== 1'b1 || out_data !== 16'd32768 || overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_take_new got=%b/%0d/%b exp=1/32768/0", out_valid, out_data, overrun);
    end
    cyc(1'b1, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0 || out_data !== 16'd32768) begin bad++; $display("FAIL ovr_drain got=%b/%0d exp=0/32768", out_valid, out_data); end
    // Set beats clear when both land in the same cycle.
    out_ready = 1'b0;
    for (int n = 1; n <= 32; n++) cyc(1'b1, 1'b1, 1'b1);
    total++; if (overrun !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL ovr_refill got=%b/%b exp=0/1", overrun, out_valid); end
    for (int n = 1; n <= 31; n++) cyc(1'b1, 1'b1, 1'b1);
    clr_ovr = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    clr_ovr = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
  endtask

  // Starts from the overrun state left by test_overrun.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int n = 1; n <= 20; n++) cyc(1'b1, 1'b1, 1'b1);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL mid_pre_ovr got=%b exp=1", overrun); end
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL mid_reset got=%b/%b exp=0/0", out_valid, overrun); end
    out_ready = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      cyc(1'b1, 1'b1, 1'b1);
      if (n < 32) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_early n=%0d got=%b exp=0", n, out_valid); end
      end
    end
    total++; if (out_valid !== 1'b1 || out_data !== 16'd5984) begin bad++; $display("FAIL mid_first got=%b/%0d exp=1/5984", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_alternating();
    test_gaps();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
